// File: rtl/bkg_sub_pkg.sv
// bkg_sub_pkg: shared states, widths and default limits for the background
// subtraction frame scheduler.
package bkg_sub_pkg;
    localparam int FRAME_PIX_MAX_DEF = 360960;
    localparam int SUB_LATENCY_DEF = 2;
    localparam int PIX_W = 19;
    localparam int FRM_W = 8;
    localparam int DAT_W = 8;
    localparam int DROP_W = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: event counter that sticks at all-ones; cleared only by reset.
module sat_counter16
    import bkg_sub_pkg::*;
(
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              inc,
    output logic [DROP_W-1:0] cnt
);
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
        if (s_axi_areset)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/bkg_sub_frame_sched.sv
// bkg_sub_frame_sched: gates dilation beats into frames for the subtractor,
// tagging sof/eof and tracking frame completion through the subtractor latency.
module bkg_sub_frame_sched
    import bkg_sub_pkg::*;
#(
    parameter int FRAME_PIX_MAX = FRAME_PIX_MAX_DEF,
    parameter int SUB_LATENCY = SUB_LATENCY_DEF
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  frame_pixels,
    input  logic [FRM_W-1:0]  num_frames,
    input  logic              dil_valid_in,
    input  logic [DAT_W-1:0]  dil_dout_in,
    output logic              dil_valid_out,
    output logic [DAT_W-1:0]  dil_dout_out,
    output logic              sof,
    output logic              eof,
    output logic              frame_done,
    output logic              run_done,
    output logic              busy,
    output logic [PIX_W-1:0]  pix_cnt,
    output logic [FRM_W-1:0]  frame_cnt,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              cfg_err,
    output logic              aborted
);
    state_t                 state;
    logic [PIX_W-1:0]       fp_q;
    logic [FRM_W-1:0]       nf_q;
    logic [7:0]             fl_cnt;
    logic [SUB_LATENCY-1:0] fd_sr;
    logic                   legal;
    logic                   last;

    assign legal = frame_pixels != '0 && frame_pixels <= PIX_W'(FRAME_PIX_MAX);
    assign last = pix_cnt == fp_q - 1'b1;
    assign busy = state != ST_IDLE;
    assign frame_done = fd_sr[SUB_LATENCY-1];

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
        if (s_axi_areset) begin
            state <= ST_IDLE;
            fp_q <= '0;
            nf_q <= '0;
            fl_cnt <= '0;
            fd_sr <= '0;
            dil_valid_out <= 1'b0;
            dil_dout_out <= '0;
            sof <= 1'b0;
            eof <= 1'b0;
            run_done <= 1'b0;
            pix_cnt <= '0;
            frame_cnt <= '0;
            cfg_err <= 1'b0;
            aborted <= 1'b0;
        end else begin
            dil_valid_out <= 1'b0;
            sof <= 1'b0;
            eof <= 1'b0;
            run_done <= 1'b0;
            // eof enters here so frame_done trails it by exactly SUB_LATENCY cycles
            fd_sr <= SUB_LATENCY'({fd_sr, eof});
            case (state)
                ST_IDLE:
                    if (start && !abort) begin
                        if (legal) begin
                            state <= ST_RUN;
                            fp_q <= frame_pixels;
                            nf_q <= num_frames;
                            pix_cnt <= '0;
                            frame_cnt <= '0;
                            cfg_err <= 1'b0;
                            aborted <= 1'b0;
                        end else
                            cfg_err <= 1'b1;
                    end
                ST_RUN:
                    if (abort) begin
                        state <= ST_FLUSH;
                        fl_cnt <= '0;
                        aborted <= 1'b1;
                    end else if (dil_valid_in) begin
                        dil_valid_out <= 1'b1;
                        dil_dout_out <= dil_dout_in;
                        sof <= pix_cnt == '0;
                        eof <= last;
                        pix_cnt <= last ? '0 : pix_cnt + 1'b1;
                        if (last) begin
                            frame_cnt <= frame_cnt + 1'b1;
                            if (nf_q != '0 && frame_cnt + 1'b1 == nf_q) begin
                                state <= ST_FLUSH;
                                fl_cnt <= '0;
                            end
                        end
                    end
                ST_FLUSH: begin
                    if (abort)
                        aborted <= 1'b1;
                    if (fl_cnt == 8'(SUB_LATENCY))
                        state <= ST_DONE;
                    else
                        fl_cnt <= fl_cnt + 1'b1;
                end
                ST_DONE: begin
                    run_done <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end

    sat_counter16 u_drop (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .inc          (dil_valid_in && state != ST_RUN),
        .cnt          (drop_cnt)
    );
endmodule

// File: tb/tb_bkg_sub_frame_sched.sv
// tb_bkg_sub_frame_sched: table-driven vectors for the main run plus directed
// sequences for abort, saturation, illegal config and async reset.
module tb_bkg_sub_frame_sched;
    import bkg_sub_pkg::*;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_areset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [18:0] frame_pixels = '0;
    logic [7:0]  num_frames = '0;
    logic        dil_valid_in = 1'b0;
    logic [7:0]  dil_dout_in = '0;
    logic        dil_valid_out;
    logic [7:0]  dil_dout_out;
    logic        sof, eof, frame_done, run_done, busy, cfg_err, aborted;
    logic [18:0] pix_cnt;
    logic [7:0]  frame_cnt;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        st;
        logic        ab;
        logic [18:0] fp;
        logic [7:0]  nf;
        logic        v;
        logic [7:0]  d;
        logic [42:0] exp;
    } vec_t;

    vec_t vq[$];

    bkg_sub_frame_sched dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_areset  (s_axi_areset),
        .start         (start),
        .abort         (abort),
        .frame_pixels  (frame_pixels),
        .num_frames    (num_frames),
        .dil_valid_in  (dil_valid_in),
        .dil_dout_in   (dil_dout_in),
        .dil_valid_out (dil_valid_out),
        .dil_dout_out  (dil_dout_out),
        .sof           (sof),
        .eof           (eof),
        .frame_done    (frame_done),
        .run_done      (run_done),
        .busy          (busy),
        .pix_cnt       (pix_cnt),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt),
        .cfg_err       (cfg_err),
        .aborted       (aborted)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        s_axi_areset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        dil_valid_in = 1'b0;
        tick();
        s_axi_areset = 1'b0;
    endtask

    task automatic add(input int st, ab, fp, nf, v, d,
                       input int vo, dout, so, eo, fd, rd, bz, pix, fc, ce, abd);
        vec_t t;
        t.st = st[0];
        t.ab = ab[0];
        t.fp = fp[18:0];
        t.nf = nf[7:0];
        t.v = v[0];
        t.d = d[7:0];
        t.exp = {vo[0], dout[7:0], so[0], eo[0], fd[0], rd[0], bz[0], pix[18:0], fc[7:0], ce[0], abd[0]};
        vq.push_back(t);
    endtask

    function automatic logic [42:0] act_vec();
        return {dil_valid_out, dil_dout_out, sof, eof, frame_done, run_done, busy,
                pix_cnt, frame_cnt, cfg_err, aborted};
    endfunction

    initial begin
        int n, seen, fdn, rdn;
        //  st ab fp nf v  d  | vo dout sof eof fd rd busy pix fcnt cerr abd
        add(1, 0, 0, 2, 0, 0,   0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 2, 1, 99,  0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 4, 2, 0, 0,   0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 4, 2, 1, 10,  1, 10, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 11,  1, 11, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        add(0, 0, 4, 2, 1, 12,  1, 12, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 4, 2, 1, 13,  1, 13, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 4, 2, 1, 14,  1, 14, 1, 0, 0, 0, 1, 1, 1, 0, 0);
        add(0, 0, 4, 2, 1, 15,  1, 15, 0, 0, 1, 0, 1, 2, 1, 0, 0);
        add(0, 0, 4, 2, 1, 16,  1, 16, 0, 0, 0, 0, 1, 3, 1, 0, 0);
        add(0, 0, 4, 2, 1, 17,  1, 17, 0, 1, 0, 0, 1, 0, 2, 0, 0);
        add(0, 0, 4, 2, 0, 0,   0, 17, 0, 0, 0, 0, 1, 0, 2, 0, 0);
        add(0, 0, 4, 2, 0, 0,   0, 17, 0, 0, 1, 0, 1, 0, 2, 0, 0);
        add(0, 0, 4, 2, 0, 0,   0, 17, 0, 0, 0, 0, 1, 0, 2, 0, 0);
        add(0, 0, 4, 2, 0, 0,   0, 17, 0, 0, 0, 1, 0, 0, 2, 0, 0);
        add(1, 1, 4, 2, 0, 0,   0, 17, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 4, 2, 1, 77,  0, 17, 0, 0, 0, 0, 0, 0, 2, 0, 0);

        #2;
        chk("reset_outputs", {act_vec(), drop_cnt}, '0);
        do_reset();
        chk("first_edge_idle", {act_vec(), drop_cnt}, '0);

        foreach (vq[i]) begin
            start = vq[i].st;
            abort = vq[i].ab;
            frame_pixels = vq[i].fp;
            num_frames = vq[i].nf;
            dil_valid_in = vq[i].v;
            dil_dout_in = vq[i].d;
            tick();
            total++;
            if (act_vec() !== vq[i].exp) begin
                bad++;
                $display("FAIL vec[%0d]: got %h want %h", i, act_vec(), vq[i].exp);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        dil_valid_in = 1'b0;
        chk("table_drop_cnt", drop_cnt, 2);

        do_reset();
        frame_pixels = 19'd360961;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("oversize_cfg_err", cfg_err, 1);
        chk("oversize_busy", busy, 0);
        dil_valid_in = 1'b1;
        tick();
        dil_valid_in = 1'b0;
        chk("oversize_no_vout", dil_valid_out, 0);

        do_reset();
        frame_pixels = 19'd3;
        num_frames = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dil_valid_in = 1'b1;
            dil_dout_in = 8'(i);
            tick();
        end
        chk("cont_frame_cnt", frame_cnt, 3);
        chk("cont_pix_cnt", pix_cnt, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        dil_valid_in = 1'b0;
        chk("abort_beat_dropped", dil_valid_out, 0);
        chk("abort_flag", aborted, 1);
        chk("abort_pix_kept", pix_cnt, 1);
        n = 0;
        while (!run_done && n < 20) begin
            tick();
            n++;
        end
        chk("abort_run_done_lat", n, 4);
        chk("abort_busy_low", busy, 0);
        chk("abort_pix_after", pix_cnt, 1);
        chk("abort_fcnt_after", frame_cnt, 3);

        do_reset();
        dil_valid_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (dil_valid_out) seen++;
            if (i == 99) chk("drop_cnt_100", drop_cnt, 100);
        end
        dil_valid_in = 1'b0;
        chk("drop_cnt_sat", drop_cnt, 65535);
        chk("idle_vout_seen", seen, 0);

        do_reset();
        frame_pixels = 19'd200;
        num_frames = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dil_valid_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dil_dout_in = 8'(i + 1);
            tick();
        end
        dil_valid_in = 1'b0;
        chk("mid_pix_cnt", pix_cnt, 100);
        chk("mid_vout", dil_valid_out, 1);
        #2;
        s_axi_areset = 1'b1;
        #1;
        chk("async_reset_all_zero", {act_vec(), drop_cnt}, '0);
        #1;
        s_axi_areset = 1'b0;
        frame_pixels = 19'd1;
        num_frames = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_reset_start", {busy, pix_cnt, frame_cnt}, {1'b1, 19'd0, 8'd0});
        dil_valid_in = 1'b1;
        dil_dout_in = 8'd55;
        tick();
        chk("one_pix_f0", {dil_valid_out, dil_dout_out, sof, eof, frame_cnt}, {1'b1, 8'd55, 1'b1, 1'b1, 8'd1});
        dil_dout_in = 8'd66;
        tick();
        dil_valid_in = 1'b0;
        chk("one_pix_f1", {dil_valid_out, dil_dout_out, sof, eof, frame_cnt}, {1'b1, 8'd66, 1'b1, 1'b1, 8'd2});
        fdn = 0;
        rdn = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (frame_done) fdn++;
            if (run_done) rdn++;
        end
        chk("one_pix_frame_done", fdn, 2);
        chk("one_pix_run_done", rdn, 1);
        chk("one_pix_busy_low", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bkg_sub_frame_sched.md
BKG_SUB_FRAME_SCHED -- requirements
Module: bkg_sub_frame_sched

Interface
REQ-001 SHALL have parameter FRAME_PIX_MAX, default 360960, meaning the largest legal frame size in pixels.
REQ-002 SHALL have parameter SUB_LATENCY, default 2, meaning the downstream subtractor's valid-in to valid-out latency in cycles.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports as listed:
- s_axi_aclk  in  1  sole clock, rising edge.
- s_axi_areset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request.
- abort  in  1  single-cycle stop request.
- frame_pixels  in  19  pixels per frame, latched at accepted start.
- num_frames  in  8  frames to run, latched at start; 0 means continuous.
- dil_valid_in / dil_dout_in  in  1/8  dilation output beat.
- dil_valid_out / dil_dout_out  out  1/8  gated beat toward the subtractor.
- sof / eof  out  1/1  first / last pixel of a frame, aligned with dil_valid_out.
- frame_done  out  1  pulse when the last enhanced pixel of a frame leaves the subtractor.
- run_done  out  1  pulse on return to IDLE.
- busy  out  1  high in any state other than IDLE.
- pix_cnt  out  19  index of the next accepted pixel in the frame.
- frame_cnt  out  8  frames completed this run.
- drop_cnt  out  16  saturating count of beats dropped outside RUN.
- cfg_err / aborted  out  1/1  sticky status, cleared at the next accepted start.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
REQ-005 SHALL move IDLE->RUN on start when 0 < frame_pixels <= FRAME_PIX_MAX and abort is low.
- Latches the configuration and zeroes pix_cnt, frame_cnt, cfg_err and aborted.
REQ-006 SHALL stay in IDLE on start with an illegal frame_pixels and set cfg_err.
REQ-007 SHALL ignore start in every state except IDLE.
REQ-008 SHALL let abort win when start and abort are both high in IDLE: no state change, no flags changed.
REQ-009 SHALL register accepted RUN beats to the outputs with 1-cycle latency: dil_valid_out=1, dil_dout_out=dil_dout_in.
REQ-010 SHALL otherwise drive dil_valid_out=0, with dil_dout_out holding its last value.
REQ-011 SHALL, in RUN, count a beat by incrementing pix_cnt.
- At pix_cnt==frame_pixels-1 the beat carries eof, pix_cnt wraps to 0 and frame_cnt increments by 1, wrapping at 255.
- The beat at pix_cnt==0 carries sof; a 1-pixel frame carries sof and eof together.
REQ-012 SHALL go RUN->FLUSH on the eof beat that makes frame_cnt equal to num_frames (num_frames != 0).
REQ-013 SHALL go RUN->FLUSH or FLUSH->FLUSH on abort.
- Sets aborted; a beat arriving in the abort cycle is dropped.
REQ-014 SHALL stay in FLUSH for exactly SUB_LATENCY+1 cycles, then go to DONE.
REQ-015 SHALL spend one cycle in DONE, pulse run_done, then return to IDLE.
REQ-016 SHALL pulse frame_done exactly SUB_LATENCY cycles after eof, via a SUB_LATENCY-deep shift register.
- Frame_done pulses already in that pipe at abort still complete.
REQ-017 SHALL increment drop_cnt for every dil_valid_in beat outside RUN, saturating at 65535, reset-only clear.
REQ-018 SHALL keep pix_cnt as a partial-frame count on abort; it is not cleared until the next start.

Reset
REQ-019 SHALL, on s_axi_areset high, immediately force the state to IDLE and every output and counter to 0, including mid-frame.
REQ-020 SHALL leave the first rising edge after reset deassertion with outputs still 0; start is honoured from that edge.

Structure
REQ-021 SHALL take the state enumeration, FRAME_PIX_MAX, SUB_LATENCY and the 19/8/16-bit width constants from shared package bkg_sub_pkg.
REQ-022 SHALL instantiate one sub-module, sat_counter16, for drop_cnt; everything else lives in this module.

Verification
REQ-023 SHALL cover: start with frame_pixels=4, num_frames=2, 8 continuous beats ->
- sof on beats 0 and 4, eof on beats 3 and 7.
- frame_done 2 cycles after each eof; frame_cnt=2.
- FLUSH lasts 3 cycles, then run_done, busy low.
REQ-024 SHALL cover: start with frame_pixels=0, and separately 360961 -> cfg_err=1, busy stays 0, no dil_valid_out.
REQ-025 SHALL cover: num_frames=0, frame_pixels=3, 10 beats, then abort ->
- frame_cnt=3, pix_cnt=1, aborted=1.
- run_done 5 cycles after abort (3 FLUSH cycles, then 1 DONE cycle).
REQ-026 SHALL cover: 70000 beats while IDLE -> drop_cnt=65535, dil_valid_out never 1.
REQ-027 SHALL cover: reset asserted at pix_cnt=100 mid-RUN -> all outputs 0 asynchronously; a following start runs a clean frame.
REQ-028 SHALL cover: start and abort high in the same IDLE cycle -> stays IDLE, aborted=0.
